bin2bcd_seq: RTL

//   Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   One digit-adjust plus shift per clock, so conversion takes BIN_W cycles regardless of DIGITS.

---
 rtl/bin2bcd_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional two's-complement input mode: define BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  rdy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  sign
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    logic [BIN_W-1:0]  sh;
    logic [BW-1:0]     bcd_w;
    logic [CW-1:0]     cnt;
    logic              ovf_acc;

    logic [BIN_W-1:0]  operand;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     bcd_nx;
    logic [BIN_W-1:0]  sh_nx;
    logic              ovf_nx;
    logic              last;

`ifdef BIN2BCD_SIGNED_EN
    logic              sign_cap;

    // Magnitude of a two's-complement operand; the most negative value
    // maps to 2^(BIN_W-1) as an unsigned number.
    always_comb begin
        operand = bin;
        if (bin[BIN_W-1]) begin
            operand = (~bin) + BIN_W'(1);
        end
    end
`else
    assign operand = bin;
    assign sign    = 1'b0;
`endif

    // Add 3 to every digit that is 5 or more, all digits in parallel.
    always_comb begin
        adj = bcd_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_w[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
            end
        end
    end

    // A set MSB in the adjusted top digit is lost by the shift: overflow.
    assign bcd_nx = {adj[BW-2:0], sh[BIN_W-1]};
    assign sh_nx  = {sh[BIN_W-2:0], 1'b0};
    assign ovf_nx = ovf_acc | adj[BW-1];
    assign last   = (cnt == CW'(BIN_W - 1));

    // Control FSM, working register and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            bcd_w    <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            rdy      <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_cap <= 1'b0;
            sign     <= 1'b0;
`endif
        end else begin
            rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        sh       <= operand;
                        bcd_w    <= '0;
                        cnt      <= '0;
                        ovf_acc  <= 1'b0;
                        busy     <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                        sign_cap <= bin[BIN_W-1];
`endif
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd_w   <= bcd_nx;
                    sh      <= sh_nx;
                    ovf_acc <= ovf_nx;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        bcd_out <= bcd_nx;
                        ovf     <= ovf_nx;
`ifdef BIN2BCD_SIGNED_EN
                        sign    <= sign_cap;
`endif
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
